// File: rtl/fma16_round_pack.sv
// Normalize/round/pack stage behind the fma16 multiply-add: raw significand in, binary16 plus flags out.
// Build option FMA16_FTZ_EN flushes nonzero subnormal results to signed zero.
module fma16_round_pack #(
    parameter int PIPE_BYPASS = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [6:0]  exp_in,
    input  logic [21:0] man_in,
    input  logic        sticky_in,
    input  logic [1:0]  kind_in,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  flags
);
    localparam logic [1:0] KIND_ZERO = 2'b01;
    localparam logic [1:0] KIND_INF  = 2'b10;
    localparam logic [1:0] KIND_NAN  = 2'b11;
    localparam logic [1:0] RM_RZ     = 2'b00;
    localparam logic [1:0] RM_RNE    = 2'b01;
    localparam logic [1:0] RM_RP     = 2'b10;

    typedef struct packed {
        logic        sign;
        logic [1:0]  kind;
        logic [1:0]  rm;
        logic [7:0]  expf;
        logic [10:0] sig;
        logic        g;
        logic        s;
    } norm_t;

    logic signed [8:0] w_exp_a;
    logic [20:0]       w_man_a;
    logic              w_st_a;
    logic [8:0]        w_shamt;
    logic [20:0]       w_man_b;
    logic [20:0]       w_lost_mask;
    logic              w_st_b;
    norm_t             w_norm;

    // Stage 1: align the leading one to bit 20, denormalize when the exponent is not positive.
    always_comb begin
        if (man_in[21]) begin
            w_man_a = man_in[21:1];
            w_exp_a = {{2{exp_in[6]}}, exp_in} + 9'sd1;
            w_st_a  = sticky_in | man_in[0];
        end else begin
            w_man_a = man_in[20:0];
            w_exp_a = {{2{exp_in[6]}}, exp_in};
            w_st_a  = sticky_in;
        end
        w_shamt     = 9'd1 - $unsigned(w_exp_a);
        w_lost_mask = '0;
        w_man_b     = w_man_a;
        w_st_b      = w_st_a;
        w_norm      = '0;
        w_norm.expf = w_exp_a[7:0];
        if (w_exp_a <= 9'sd0) begin
            w_norm.expf = 8'd0;
            if (w_shamt >= 9'd21) begin
                w_man_b = '0;
                w_st_b  = w_st_a | (|w_man_a);
            end else begin
                w_lost_mask = (21'd1 << w_shamt[4:0]) - 21'd1;
                w_man_b     = w_man_a >> w_shamt[4:0];
                w_st_b      = w_st_a | (|(w_man_a & w_lost_mask));
            end
        end
        w_norm.sign = sign_in;
        w_norm.kind = kind_in;
        w_norm.rm   = roundmode;
        w_norm.sig  = w_man_b[20:10];
        w_norm.g    = w_man_b[9];
        w_norm.s    = (|w_man_b[8:0]) | w_st_b;
    end

    logic  r_out_valid;
    logic  [15:0] r_result;
    logic  [3:0]  r_flags;
    logic  w_s2_adv;
    logic  w_s1_valid;
    norm_t w_s1_q;

    assign w_s2_adv = ~r_out_valid | out_ready;

    generate
        if (PIPE_BYPASS != 0) begin : g_bypass
            assign w_s1_valid = in_valid;
            assign w_s1_q     = w_norm;
            assign in_ready   = w_s2_adv;
        end else begin : g_pipe
            logic  r_s1_valid;
            norm_t r_s1;
            logic  w_s1_adv;
            assign w_s1_adv = ~r_s1_valid | w_s2_adv;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1       <= '0;
                end else if (w_s1_adv) begin
                    r_s1_valid <= in_valid;
                    if (in_valid) r_s1 <= w_norm;
                end
            end
            assign w_s1_valid = r_s1_valid;
            assign w_s1_q     = r_s1;
            assign in_ready   = w_s1_adv;
        end
    endgenerate

    logic        w_inc;
    logic        w_inexact;
    logic        w_tiny;
    logic        w_ovf;
    logic [17:0] w_sum;
    logic [15:0] w_res;
    logic [3:0]  w_flg;

    // Stage 2: the increment carries straight through {expfield, frac}, so subnormal->normal is free.
    always_comb begin
        w_inexact = w_s1_q.g | w_s1_q.s;
        w_tiny    = ~w_s1_q.sig[10];
        case (w_s1_q.rm)
            RM_RZ:   w_inc = 1'b0;
            RM_RNE:  w_inc = w_s1_q.g & (w_s1_q.s | w_s1_q.sig[0]);
            RM_RP:   w_inc = ~w_s1_q.sign & w_inexact;
            default: w_inc = w_s1_q.sign & w_inexact;
        endcase
        w_sum = {w_s1_q.expf, w_s1_q.sig[9:0]} + {17'd0, w_inc};
        w_ovf = (w_sum[17:10] >= 8'd31);
        w_res = {w_s1_q.sign, w_sum[14:0]};
        w_flg = {2'b00, w_tiny & w_inexact, w_inexact};
        if (w_ovf) begin
            case (w_s1_q.rm)
                RM_RZ:   w_res = {w_s1_q.sign, 15'h7BFF};
                RM_RNE:  w_res = {w_s1_q.sign, 15'h7C00};
                RM_RP:   w_res = w_s1_q.sign ? 16'hFBFF : 16'h7C00;
                default: w_res = w_s1_q.sign ? 16'hFC00 : 16'h7BFF;
            endcase
            w_flg = 4'b0101;
        end
`ifdef FMA16_FTZ_EN
        else if (w_sum[14:10] == 5'd0 && w_sum[9:0] != 10'd0) begin
            w_res = {w_s1_q.sign, 15'd0};
            w_flg = 4'b0011;
        end
`endif
        case (w_s1_q.kind)
            KIND_ZERO: begin w_res = {w_s1_q.sign, 15'h0000}; w_flg = 4'b0000; end
            KIND_INF:  begin w_res = {w_s1_q.sign, 15'h7C00}; w_flg = 4'b0000; end
            KIND_NAN:  begin w_res = 16'h7E00;                w_flg = 4'b1000; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= 16'h0000;
            r_flags     <= 4'b0000;
        end else if (w_s2_adv) begin
            r_out_valid <= w_s1_valid;
            if (w_s1_valid) begin
                r_result <= w_res;
                r_flags  <= w_flg;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
endmodule

// File: tb/tb_fma16_round_pack.sv
// Bench for fma16_round_pack: directed corner cases, backpressure, reset, and a random scoreboard run
// against an exact-value rounding model.
module tb_fma16_round_pack;
    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [6:0]  exp_in;
    logic [21:0] man_in;
    logic        sticky_in;
    logic [1:0]  kind_in;
    logic [1:0]  roundmode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags;

    int n_vec;
    int n_err;
    logic [19:0] exp_q[$];

    fma16_round_pack dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .man_in(man_in), .sticky_in(sticky_in),
        .kind_in(kind_in), .roundmode(roundmode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exact model: the input value is m * 2^(e-35); scaled by 2^105 it is an integer, with the
    // upstream sticky as one extra bit below everything. Binary16 ulp is never finer than 2^-24.
    function automatic logic [19:0] ref_model(input logic s, input logic [6:0] e7, input logic [21:0] m,
                                              input logic st, input logic [1:0] k, input logic [1:0] rm);
        logic [159:0] w, rem, half, t, val;
        int e, p, sh, f;
        logic up, inexact, tiny;
        logic [15:0] r;
        if (k == 2'b01) return {s, 15'd0, 4'b0000};
        if (k == 2'b10) return {s, 15'h7C00, 4'b0000};
        if (k == 2'b11) return {16'h7E00, 4'b1000};
        e = int'($signed(e7));
        w = (160'(m) << (e + 70)) | 160'(st);
        p = 0;
        for (int i = 0; i < 160; i++) if (w[i]) p = i;
        sh = (p - 10 > 81) ? p - 10 : 81;
        t = w >> sh;
        rem = w & ((160'd1 << sh) - 160'd1);
        half = 160'd1 << (sh - 1);
        inexact = (rem != 0);
        tiny = (w < (160'd1 << 91));
        case (rm)
            2'b00:   up = 1'b0;
            2'b01:   up = (rem > half) || (rem == half && t[0]);
            2'b10:   up = !s && inexact;
            default: up = s && inexact;
        endcase
        val = (t + 160'(up)) << (sh - 81);
        if (val >= (160'd1 << 40)) begin
            case (rm)
                2'b00:   r = {s, 15'h7BFF};
                2'b01:   r = {s, 15'h7C00};
                2'b10:   r = s ? 16'hFBFF : 16'h7C00;
                default: r = s ? 16'hFC00 : 16'h7BFF;
            endcase
            return {r, 4'b0101};
        end
`ifdef FMA16_FTZ_EN
        if (val != 0 && val < 1024) return {s, 15'd0, 4'b0011};
`endif
        if (val < 1024) begin
            r = {s, 15'(val)};
        end else begin
            p = 0;
            for (int i = 0; i < 41; i++) if (val[i]) p = i;
            f = p - 9;
            r = {s, 5'(f), 10'(val >> (f - 1))};
        end
        return {r, 2'b00, tiny && inexact, inexact};
    endfunction

    task automatic drive_item(input logic s, input logic [6:0] e, input logic [21:0] m,
                              input logic st, input logic [1:0] k, input logic [1:0] rm);
        int budget;
        in_valid = 1'b1; sign_in = s; exp_in = e; man_in = m;
        sticky_in = st; kind_in = k; roundmode = rm;
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL in_ready_timeout: in_ready=%b want 1 within 200 cycles", in_ready);
        end else begin
            exp_q.push_back(ref_model(s, e, m, st, k, rm));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic rand_drive();
        logic s, st;
        logic [1:0] k, rm;
        logic [21:0] m;
        int e;
        s  = 1'($urandom_range(1));
        rm = 2'($urandom_range(3));
        k  = ($urandom_range(15) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
        case ($urandom_range(3))
            0:       e = int'($urandom_range(127)) - 64;
            1:       e = int'($urandom_range(35)) - 25;
            2:       e = int'($urandom_range(12)) + 25;
            default: e = int'($urandom_range(25)) + 5;
        endcase
        m = ($urandom_range(1) == 1) ? {1'b1, 21'($urandom)} : {2'b01, 20'($urandom)};
        if ($urandom_range(3) == 0) m[9:0] = 10'h200;
        st = ($urandom_range(3) == 0);
        drive_item(s, 7'(e), m, st, k, rm);
    endtask

    task automatic get_one(output logic [15:0] r, output logic [3:0] f, output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = result;
        f = flags;
        @(posedge clk); #1;
    endtask

    task automatic collect(input int n, input int ready_pct);
        int got, idle;
        logic [19:0] e;
        got = 0; idle = 0;
        while (got < n && idle < 500) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got %h/%b, no result expected", result, flags);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, flags} !== e) begin
                        n_err++;
                        $display("FAIL stream_result: got %h/%b want %h/%b", result, flags, e[19:4], e[3:0]);
                    end
                end
                got++; idle = 0;
            end else begin
                idle++;
            end
        end
        if (got < n) begin
            n_vec++; n_err++;
            $display("FAIL collect_timeout: got %0d results want %0d", got, n);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sign_in = 0; exp_in = 0; man_in = 0; sticky_in = 0; kind_in = 0; roundmode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result: got %h want 0000", result); end
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic        t_sign [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1};
        logic [6:0]  t_exp  [11] = '{15, 15, 15, 15, 31, 31, 31, 0, 15, 15, 15};
        logic [21:0] t_man  [11] = '{22'h100000, 22'h240000, 22'h100200, 22'h100600, 22'h100000,
                                     22'h100000, 22'h100000, 22'h100000, 22'h100000, 22'h100000, 22'h100000};
        logic [1:0]  t_rm   [11] = '{1, 1, 1, 1, 1, 0, 2, 1, 1, 1, 1};
        logic [1:0]  t_kind [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 2};
        logic [15:0] t_res  [11] = '{16'h3C00, 16'h4080, 16'h3C00, 16'h3C02, 16'h7C00, 16'h7BFF, 16'hFBFF,
`ifdef FMA16_FTZ_EN
                                     16'h0000,
`else
                                     16'h0200,
`endif
                                     16'h7E00, 16'h8000, 16'hFC00};
        logic [3:0]  t_flg  [11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0101,
`ifdef FMA16_FTZ_EN
                                     4'b0011,
`else
                                     4'b0000,
`endif
                                     4'b1000, 4'b0000, 4'b0000};
        logic [15:0] r;
        logic [3:0]  f;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive_item(t_sign[i], t_exp[i], t_man[i], 1'b0, t_kind[i], t_rm[i]);
            get_one(r, f, lat);
            exp_q.delete();
            n_vec++;
            if (r !== t_res[i]) begin n_err++; $display("FAIL basic_result[%0d]: got %h want %h", i, r, t_res[i]); end
            n_vec++;
            if (f !== t_flg[i]) begin n_err++; $display("FAIL basic_flags[%0d]: got %b want %b", i, f, t_flg[i]); end
            if (i == 0) begin
                n_vec++;
                if (lat != 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", lat); end
            end
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete();
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 4; i++) rand_drive();
            begin
                int w;
                logic [15:0] held_r;
                logic [3:0]  held_f;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin @(negedge clk); w++; end
                held_r = result; held_f = flags;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    n_vec++;
                    if (!out_valid || result !== held_r || flags !== held_f) begin
                        n_err++;
                        $display("FAIL bp_hold: got %b %h/%b want 1 %h/%b", out_valid, result, flags, held_r, held_f);
                    end
                    n_vec++;
                    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
                end
                n_vec++;
                if (exp_q.size() != 2) begin n_err++; $display("FAIL bp_accepted: got %0d want 2", exp_q.size()); end
                collect(4, 100);
            end
        join
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        out_ready = 1'b1;
        fork
            for (int i = 0; i < 16; i++) rand_drive();
            begin
                int got, waitc, gaps;
                logic [19:0] e;
                got = 0; waitc = 0; gaps = 0;
                while (got < 16 && waitc < 100) begin
                    @(negedge clk);
                    if (out_valid) begin
                        n_vec++;
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'hxxxxx;
                        if ({result, flags} !== e) begin
                            n_err++;
                            $display("FAIL b2b_result: got %h/%b want %h/%b", result, flags, e[19:4], e[3:0]);
                        end
                        got++;
                    end else begin
                        waitc++;
                        if (got > 0) gaps++;
                    end
                end
                n_vec++;
                if (got != 16 || gaps != 0) begin
                    n_err++;
                    $display("FAIL b2b_throughput: got %0d results %0d gaps want 16 results 0 gaps", got, gaps);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_reset_inflight();
        exp_q.delete();
        out_ready = 1'b0;
        rand_drive();
        rand_drive();
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flush_valid: got %b want 0", out_valid); end
        n_vec++;
        if (result !== 16'h0000) begin n_err++; $display("FAIL rst_flush_result: got %h want 0000", result); end
        reset_n = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale_output: got %b want 0", out_valid); end
        end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_q.delete();
        fork
            for (int i = 0; i < 400; i++) begin
                rand_drive();
                if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
            end
            collect(400, 70);
        join
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
